// File: rtl/oet_sorter.sv
// Odd-even transposition sorter: accepts an N-element vector, sorts it one
// compare-exchange phase per clock and stops early once the array is stable.
module oet_sorter #(
  parameter int N      = 8,
  parameter int W      = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*W-1:0]             in_data,
  input  logic                       in_desc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*W-1:0]             out_data,
  output logic [$clog2(N+1)-1:0]     out_phases,
  output logic [1:0]                 dbg_state
);

  // Handshake: a transfer completes on a rising clk edge where valid and
  // ready are both high; the sender holds valid and its payload until then.

  localparam int PW = $clog2(N+1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N*W-1:0]   arr_q, arr_d;
  logic             desc_q, desc_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             prev_swap_q, prev_swap_d;
  logic [PW-1:0]    out_phases_q, out_phases_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [N*W-1:0]   sorted;
  logic             swapped_now;
  logic [PW-1:0]    phase_next;
  logic             exit_now;
  logic [W-1:0]     elem_a, elem_b;

  function automatic logic needs_swap(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic desc);
    logic a_lt_b, a_gt_b;
    if (SIGNED) begin
      a_lt_b = $signed(a) < $signed(b);
      a_gt_b = $signed(a) > $signed(b);
    end else begin
      a_lt_b = a < b;
      a_gt_b = a > b;
    end
    return desc ? a_lt_b : a_gt_b;
  endfunction

  always_comb begin
    sorted      = arr_q;
    swapped_now = 1'b0;
    elem_a      = '0;
    elem_b      = '0;
    // Pairs start at even indices on even phases, odd indices on odd phases.
    for (int i = 0; i < N - 1; i++) begin
      if (i[0] == phase_q[0]) begin
        elem_a = arr_q[i*W +: W];
        elem_b = arr_q[(i+1)*W +: W];
        if (needs_swap(elem_a, elem_b, desc_q)) begin
          sorted[i*W +: W]     = elem_b;
          sorted[(i+1)*W +: W] = elem_a;
          swapped_now          = 1'b1;
        end
      end
    end
    phase_next = phase_q + PW'(1);
    exit_now   = ((phase_next >= PW'(2)) && !swapped_now && !prev_swap_q) ||
                 (phase_next == PW'(N));
  end

  always_comb begin
    state_d      = state_q;
    arr_d        = arr_q;
    desc_d       = desc_q;
    phase_d      = phase_q;
    prev_swap_d  = prev_swap_q;
    out_phases_d = out_phases_q;
    out_valid_d  = out_valid_q;
    in_ready_d   = in_ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          arr_d       = in_data;
          desc_d      = in_desc;
          phase_d     = '0;
          prev_swap_d = 1'b0;
          in_ready_d  = 1'b0;
          state_d     = SORT;
        end
      end
      SORT: begin
        arr_d       = sorted;
        phase_d     = phase_next;
        prev_swap_d = swapped_now;
        if (exit_now) begin
          out_phases_d = phase_next;
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      arr_q        <= '0;
      desc_q       <= 1'b0;
      phase_q      <= '0;
      prev_swap_q  <= 1'b0;
      out_phases_q <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      arr_q        <= arr_d;
      desc_q       <= desc_d;
      phase_q      <= phase_d;
      prev_swap_q  <= prev_swap_d;
      out_phases_q <= out_phases_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = arr_q;
  assign out_phases = out_phases_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/oet_sorter.md
Name: oet_sorter

Overview:
- Parametrised odd-even transposition sorter. Generalises the single compare-exchange element to a full N-element, W-bit array.
- Sits between an upstream producer and a downstream consumer. Each side uses a valid/ready handshake.
- Accepts one parallel vector per transaction and sorts it ascending or descending using alternating even/odd compare-exchange phases, one phase per clock.
- Terminates early once the array is stable, and reports the number of phases used.

Parameters:
- N, 8, number of elements; legal values N >= 2.
- W, 32, element width in bits.
- SIGNED, 0, compare mode: 1 = two's-complement compare, 0 = unsigned compare.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- in_valid, input, 1, upstream vector valid.
- in_ready, output, 1, sorter can accept a vector.
- in_data, input, N*W, element i occupies bits [i*W +: W].
- in_desc, input, 1, sort order, sampled with in_data: 1 = descending, 0 = ascending.
- out_valid, output, 1, sorted vector available.
- out_ready, input, 1, downstream accepts the vector.
- out_data, output, N*W, sorted vector, same element packing as in_data.
- out_phases, output, $clog2(N+1), number of phases executed for this vector.

Behaviour:
- Reset (asynchronous, any state, including mid-sort):
  - State goes to IDLE.
  - Array registers, out_phases and phase counter clear to 0.
  - in_ready=1, out_valid=0, out_data=0.
  - Any in-flight vector is discarded.
- FSM states are IDLE, SORT and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready: capture in_data into the array and latch in_desc, clear phase counter and swap flags, then go to SORT.
- SORT:
  - in_ready=0, out_valid=0.
  - Each cycle executes phase p, where p = phase counter value.
  - Even p compares pairs (0,1),(2,4−1)... i.e. (0,1),(2,3),...
  - Odd p compares pairs (1,2),(3,4),...
  - Elements not in any pair this phase hold their value.
- Compare-exchange rule:
  - Ascending: swap when a[i] > a[i+1].
  - Descending: swap when a[i] < a[i+1].
  - Equal values never swap and never count as a swap.
  - Comparison is signed when SIGNED=1, otherwise unsigned.
- Phase bookkeeping:
  - Each phase records swapped_now = OR of all pair swaps.
  - The phase counter increments once per phase.
- Exit from SORT to DONE after the phase that makes the count P, when either condition holds:
  - (P >= 2 and the current and previous phases both had zero swaps), or
  - P == N.
  - On exit, out_phases is loaded with P.
- DONE:
  - out_valid=1, out_data equals the array.
  - out_data and out_phases stay stable while out_ready=0.
  - When out_valid&&out_ready: go to IDLE; out_valid drops the next cycle.
- Simultaneous acceptance is not supported: in_ready is low in SORT and DONE, so an input and an output transfer never complete in the same cycle.
- Latency:
  - Input accepted at edge k gives out_valid=1 after edge k+P.
  - Minimum P=2, maximum P=N.
- out_data and out_phases are registered outputs; no combinational path from inputs to outputs except through the FSM.

Test Plan:
- N=8, ascending, in = {0,1,...,7} (element 0 first) -> out_valid 2 cycles after accept, out_data unchanged, out_phases=2.
- N=8, ascending, in = {7,6,5,4,3,2,1,0} -> out_data {0..7}, out_phases=8, out_valid exactly 8 cycles after accept.
- N=8, in_desc=1, in = {3,9,1,9,0,5,5,2} -> out_data {9,9,5,5,3,2,1,0}; equal pairs are not swapped.
- SIGNED=1, W=8, in = {0x01,0xFF,0x80,0x7F,...} ascending -> 0x80 (−128) first, 0xFF (−1) before 0x01. Same vector with SIGNED=0 -> 0x01 first, 0xFF last.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_data and out_phases stable, in_ready=0; in_valid asserted meanwhile is not accepted. Raise out_ready -> IDLE next cycle, in_ready=1.
- Assert rst 3 cycles into a sort of a reverse vector -> out_valid=0, in_ready=1 immediately. A following vector {2,1} on N=2 sorts to {1,2}, out_phases=2, with no residue from the aborted vector.
